e203_exu_excp_irq_arb: RTL and testbench

//  Parametrised trap arbiter for the EXU commit stage. It merges commit-time synchronous exceptions,
//  NUM_IRQ level interrupt channels and the WFI halt/sleep sequence. Its output is one flush request

---
 rtl/e203_exu_excp_irq_arb_if.sv | 27 ++
 rtl/e203_exu_excp_irq_arb.sv | 173 +++++++++++++++++
 tb/tb_e203_exu_excp_irq_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_exu_excp_irq_arb_if.sv
// Flush handshake bundle between the EXU trap arbiter and the IFU.
//   flush_req : flush request, held until flush_ack
//   flush_ack : IFU accepts the flush
//   flush_pc  : flush target PC
//   cause_o   : mcause value (bit XLEN-1 = interrupt)
//   epc_o     : mepc value
//   mepc_ena  : single-cycle strobe to write mcause/mepc
interface e203_exu_excp_irq_arb_if #(
  parameter int XLEN = 32
);
  logic            flush_req;
  logic            flush_ack;
  logic [XLEN-1:0] flush_pc;
  logic [XLEN-1:0] cause_o;
  logic [XLEN-1:0] epc_o;
  logic            mepc_ena;

  modport master (
    output flush_req, flush_pc, cause_o, epc_o, mepc_ena,
    input  flush_ack
  );

  modport slave (
    input  flush_req, flush_pc, cause_o, epc_o, mepc_ena,
    output flush_ack
  );
endinterface

// File: rtl/e203_exu_excp_irq_arb.sv
// Commit-stage trap arbiter. Merges synchronous exceptions, NUM_IRQ level
// interrupt channels and the WFI halt/sleep sequence into one flush request
// toward the IFU, held until acknowledged.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   irq_i, irq_en_i       per-channel pending level and enable
//   status_mie_r          global interrupt enable
//   dbg_mode              core in debug mode (masks interrupts and WFI)
//   cmt_ena, cmt_pc_i     commit strobe and PC of committing instruction
//   excp_valid_i/cause_i  commit-time exception and its code
//   wfi_i                 committing instruction is WFI
//   wfi_halt_ack          IFU/EXU halted
//   csr_mtvec_r           trap vector CSR
//   flush_if              flush handshake (master side)
//   wfi_halt_req          halt request to IFU/EXU
//   wfi_sleep             core asleep in WFI
module e203_exu_excp_irq_arb #(
  parameter int NUM_IRQ       = 4,
  parameter int XLEN          = 32,
  parameter int IRQ_CODE_BASE = 16,
  parameter int VECTORED      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_en_i,
  input  logic                  status_mie_r,
  input  logic                  dbg_mode,
  input  logic                  cmt_ena,
  input  logic [XLEN-1:0]       cmt_pc_i,
  input  logic                  excp_valid_i,
  input  logic [4:0]            excp_cause_i,
  input  logic                  wfi_i,
  input  logic                  wfi_halt_ack,
  input  logic [XLEN-1:0]       csr_mtvec_r,
  e203_exu_excp_irq_arb_if.master flush_if,
  output logic                  wfi_halt_req,
  output logic                  wfi_sleep
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALT  = 2'd1,
    ST_SLEEP = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] flush_pc_q, flush_pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;
  logic            trap_q, trap_d;

  // Interrupt qualification. wake deliberately ignores mie/debug so a
  // masked interrupt still ends WFI sleep (resume path, no trap).
  logic [NUM_IRQ-1:0] irq_act;
  logic               wake;
  logic               irq_hit;
  logic [IDX_W-1:0]   irq_idx;

  assign irq_act = irq_i & irq_en_i;
  assign wake    = |irq_act;
  assign irq_hit = wake & status_mie_r & ~dbg_mode;

  // Lowest active channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    irq_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_act[k]) irq_idx = IDX_W'(k);
    end
  end

  logic [XLEN-1:0] irq_code;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] mtvec_base;
  logic            vec_mode;
  logic [XLEN-1:0] irq_tgt;
  logic [XLEN-1:0] wfi_npc;

  assign irq_code   = XLEN'(IRQ_CODE_BASE) + XLEN'(irq_idx);
  assign irq_cause  = {1'b1, irq_code[XLEN-2:0]};
  assign mtvec_base = {csr_mtvec_r[XLEN-1:2], 2'b00};
  assign vec_mode   = (VECTORED != 0) && (csr_mtvec_r[1:0] == 2'b01);
  // Both sums wrap modulo 2^XLEN by construction.
  assign irq_tgt    = vec_mode ? (mtvec_base + (irq_code << 2)) : mtvec_base;
  assign wfi_npc    = wfi_pc_q + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    wfi_pc_d   = wfi_pc_q;
    trap_d     = trap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmt_ena) begin
          if (excp_valid_i) begin
            state_d    = ST_FLUSH;
            trap_d     = 1'b1;
            cause_d    = XLEN'(excp_cause_i);
            epc_d      = cmt_pc_i;
            flush_pc_d = mtvec_base;
          end else if (irq_hit) begin
            // Committing instruction is cancelled; mepc points at it.
            state_d    = ST_FLUSH;
            trap_d     = 1'b1;
            cause_d    = irq_cause;
            epc_d      = cmt_pc_i;
            flush_pc_d = irq_tgt;
          end else if (wfi_i && !dbg_mode) begin
            state_d  = ST_HALT;
            wfi_pc_d = cmt_pc_i;
          end
        end
      end
      ST_HALT, ST_SLEEP: begin
        if (wake) begin
          state_d = ST_FLUSH;
          if (irq_hit) begin
            trap_d     = 1'b1;
            cause_d    = irq_cause;
            epc_d      = wfi_npc;
            flush_pc_d = irq_tgt;
          end else begin
            // Plain resume after WFI: mcause/mepc are left untouched.
            trap_d     = 1'b0;
            flush_pc_d = wfi_npc;
          end
        end else if (state_q == ST_HALT && wfi_halt_ack) begin
          state_d = ST_SLEEP;
        end
      end
      ST_FLUSH: begin
        // Commit-side events are dropped here; upstream stalls commit.
        if (flush_if.flush_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flush_pc_q <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      wfi_pc_q   <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      wfi_pc_q   <= wfi_pc_d;
      trap_q     <= trap_d;
    end
  end

  // Status outputs decode straight from the state flop so async reset
  // removes them immediately.
  assign flush_if.flush_req = (state_q == ST_FLUSH);
  assign flush_if.flush_pc  = flush_pc_q;
  assign flush_if.cause_o   = cause_q;
  assign flush_if.epc_o     = epc_q;
  assign flush_if.mepc_ena  = (state_q == ST_FLUSH) & flush_if.flush_ack & trap_q;
  assign wfi_halt_req       = (state_q == ST_HALT) || (state_q == ST_SLEEP);
  assign wfi_sleep          = (state_q == ST_SLEEP);

endmodule

// File: tb/tb_e203_exu_excp_irq_arb.sv
module tb_e203_exu_excp_irq_arb;
  localparam int NI = 4;
  localparam int XL = 32;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] irq_i = '0, irq_en_i = '0;
  logic          status_mie_r = 0, dbg_mode = 0, cmt_ena = 0;
  logic [XL-1:0] cmt_pc_i = '0, csr_mtvec_r = '0;
  logic          excp_valid_i = 0, wfi_i = 0, wfi_halt_ack = 0, flush_ack = 0;
  logic [4:0]    excp_cause_i = '0;
  logic          halt_v, sleep_v, halt_d, sleep_d;

  int n_chk = 0;
  int n_fail = 0;
  int mepc_cnt = 0;

  always #5 clk = ~clk;

  e203_exu_excp_irq_arb_if #(.XLEN(XL)) if_v ();
  e203_exu_excp_irq_arb_if #(.XLEN(XL)) if_d ();
  assign if_v.flush_ack = flush_ack;
  assign if_d.flush_ack = flush_ack;

  e203_exu_excp_irq_arb #(.NUM_IRQ(NI), .XLEN(XL), .IRQ_CODE_BASE(CB), .VECTORED(1)) dut_v (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i), .status_mie_r(status_mie_r),
    .dbg_mode(dbg_mode), .cmt_ena(cmt_ena), .cmt_pc_i(cmt_pc_i), .excp_valid_i(excp_valid_i),
    .excp_cause_i(excp_cause_i), .wfi_i(wfi_i), .wfi_halt_ack(wfi_halt_ack),
    .csr_mtvec_r(csr_mtvec_r), .flush_if(if_v), .wfi_halt_req(halt_v), .wfi_sleep(sleep_v));

  e203_exu_excp_irq_arb #(.NUM_IRQ(NI), .XLEN(XL), .IRQ_CODE_BASE(CB), .VECTORED(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i), .status_mie_r(status_mie_r),
    .dbg_mode(dbg_mode), .cmt_ena(cmt_ena), .cmt_pc_i(cmt_pc_i), .excp_valid_i(excp_valid_i),
    .excp_cause_i(excp_cause_i), .wfi_i(wfi_i), .wfi_halt_ack(wfi_halt_ack),
    .csr_mtvec_r(csr_mtvec_r), .flush_if(if_d), .wfi_halt_req(halt_d), .wfi_sleep(sleep_d));

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "a flush is pending", "waiting for halt", "asleep" as independent
  // facts plus the values the flush must carry.
  bit            m_flush, m_wait, m_sleep, m_trap;
  logic [XL-1:0] m_pc, m_pc_nv, m_cause, m_epc, m_wpc;

  function automatic logic [XL-1:0] target(input logic [XL-1:0] mtvec, input int code, input bit vec);
    logic [XL-1:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (vec && mtvec[1:0] == 2'b01) return base + 32'(4 * code);
    return base;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flush <= 0; m_wait <= 0; m_sleep <= 0; m_trap <= 0;
      m_pc <= '0; m_pc_nv <= '0; m_cause <= '0; m_epc <= '0; m_wpc <= '0;
    end else begin
      automatic int  ch = -1;
      automatic bit  wk, hit;
      for (int k = 0; k < NI; k++) if (ch < 0 && irq_i[k] && irq_en_i[k]) ch = k;
      wk  = (ch >= 0);
      hit = wk && status_mie_r && !dbg_mode;
      if (m_flush) begin
        if (flush_ack) m_flush <= 0;
      end else if (m_wait || m_sleep) begin
        if (wk) begin
          m_flush <= 1; m_wait <= 0; m_sleep <= 0;
          if (hit) begin
            m_trap <= 1; m_cause <= 32'h8000_0000 + 32'(CB + ch); m_epc <= m_wpc + 4;
            m_pc <= target(csr_mtvec_r, CB + ch, 1); m_pc_nv <= target(csr_mtvec_r, CB + ch, 0);
          end else begin
            m_trap <= 0; m_pc <= m_wpc + 4; m_pc_nv <= m_wpc + 4;
          end
        end else if (m_wait && wfi_halt_ack) begin
          m_wait <= 0; m_sleep <= 1;
        end
      end else if (cmt_ena) begin
        if (excp_valid_i) begin
          m_flush <= 1; m_trap <= 1; m_cause <= 32'(excp_cause_i); m_epc <= cmt_pc_i;
          m_pc <= target(csr_mtvec_r, 0, 0); m_pc_nv <= target(csr_mtvec_r, 0, 0);
        end else if (hit) begin
          m_flush <= 1; m_trap <= 1; m_cause <= 32'h8000_0000 + 32'(CB + ch); m_epc <= cmt_pc_i;
          m_pc <= target(csr_mtvec_r, CB + ch, 1); m_pc_nv <= target(csr_mtvec_r, CB + ch, 0);
        end else if (wfi_i && !dbg_mode) begin
          m_wait <= 1; m_wpc <= cmt_pc_i;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("flush_req", 32'(if_v.flush_req), 32'(m_flush));
    chk("flush_pc", if_v.flush_pc, m_pc);
    chk("cause_o", if_v.cause_o, m_cause);
    chk("epc_o", if_v.epc_o, m_epc);
    chk("mepc_ena", 32'(if_v.mepc_ena), 32'(m_flush && flush_ack && m_trap));
    chk("wfi_halt_req", 32'(halt_v), 32'(m_wait || m_sleep));
    chk("wfi_sleep", 32'(sleep_v), 32'(m_sleep));
    chk("nv_flush_req", 32'(if_d.flush_req), 32'(m_flush));
    chk("nv_flush_pc", if_d.flush_pc, m_pc_nv);
    chk("nv_cause_o", if_d.cause_o, m_cause);
    if (if_v.mepc_ena) mepc_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ack();
    flush_ack = 1; tick(); flush_ack = 0;
  endtask

  task automatic commit(input logic [XL-1:0] pc, input bit ex, input logic [4:0] c, input bit wfi);
    cmt_ena = 1; cmt_pc_i = pc; excp_valid_i = ex; excp_cause_i = c; wfi_i = wfi;
    tick();
    cmt_ena = 0; excp_valid_i = 0; wfi_i = 0;
  endtask

  int base_cnt;

  initial begin
    repeat (3) tick();
    chk("rst_flush_req", 32'(if_v.flush_req), 0);
    chk("rst_halt", 32'(halt_v), 0);
    chk("rst_cause", if_v.cause_o, 0);
    rst_n = 1; tick();

    // T1 exception, late ack
    csr_mtvec_r = 32'h8000_0000; base_cnt = mepc_cnt;
    commit(32'h8000_0100, 1, 5'd2, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", 32'(if_v.flush_req), 1);
      chk("t1_pc", if_v.flush_pc, 32'h8000_0000);
      chk("t1_cause", if_v.cause_o, 32'h2);
      chk("t1_epc", if_v.epc_o, 32'h8000_0100);
      tick();
    end
    ack();
    chk("t1_req_drop", 32'(if_v.flush_req), 0);
    chk("t1_mepc_pulses", 32'(mepc_cnt - base_cnt), 1);

    // T2 vectored interrupt, channel 2
    csr_mtvec_r = 32'h8000_0001; status_mie_r = 1; irq_i = 4'b0100; irq_en_i = 4'b0100;
    commit(32'h1000, 0, 0, 0);
    irq_i = 0;
    chk("t2_cause", if_v.cause_o, 32'h8000_0012);
    chk("t2_pc_vec", if_v.flush_pc, 32'h8000_0048);
    chk("t2_pc_direct", if_d.flush_pc, 32'h8000_0000);
    chk("t2_epc", if_v.epc_o, 32'h1000);
    ack();

    // T3 priority: exception beats interrupt; lowest channel wins
    irq_i = 4'b1010; irq_en_i = 4'b1010;
    commit(32'h2000, 1, 5'd5, 0);
    chk("t3_excp_cause", if_v.cause_o, 32'h5);
    ack();
    commit(32'h2004, 0, 0, 0);
    chk("t3_irq_cause", if_v.cause_o, 32'h8000_0011);
    ack();
    irq_i = 0;

    // T4 WFI resume with mie=0
    status_mie_r = 0; irq_en_i = 4'b0001; base_cnt = mepc_cnt;
    commit(32'h200, 0, 0, 1);
    chk("t4_halt_req", 32'(halt_v), 1);
    chk("t4_not_sleep", 32'(sleep_v), 0);
    wfi_halt_ack = 1; tick(); wfi_halt_ack = 0;
    chk("t4_sleep", 32'(sleep_v), 1);
    tick();
    chk("t4_still_sleep", 32'(sleep_v), 1);
    irq_i = 4'b0001; tick(); irq_i = 0;
    chk("t4_resume_req", 32'(if_v.flush_req), 1);
    chk("t4_resume_pc", if_v.flush_pc, 32'h204);
    chk("t4_halt_drop", 32'(halt_v), 0);
    chk("t4_sleep_drop", 32'(sleep_v), 0);
    ack();
    chk("t4_no_mepc", 32'(mepc_cnt - base_cnt), 0);
    // same with mie=1: trap, woken from HALT_REQ directly
    status_mie_r = 1; csr_mtvec_r = 32'h8000_0000;
    commit(32'h200, 0, 0, 1);
    irq_i = 4'b0001; tick(); irq_i = 0;
    chk("t4_trap_epc", if_v.epc_o, 32'h204);
    chk("t4_trap_cause", if_v.cause_o, 32'h8000_0010);
    chk("t4_trap_pc", if_v.flush_pc, 32'h8000_0000);
    ack();
    chk("t4_trap_mepc", 32'(mepc_cnt - base_cnt), 1);

    // T5 async reset mid-FLUSH and mid-SLEEP
    commit(32'h300, 1, 5'd3, 0);
    chk("t5_in_flush", 32'(if_v.flush_req), 1);
    rst_n = 0; #1;
    chk("t5_flush_async", 32'(if_v.flush_req), 0);
    tick(); rst_n = 1; tick();
    chk("t5_idle_flush", 32'(if_v.flush_req), 0);
    status_mie_r = 0;
    commit(32'h400, 0, 0, 1);
    wfi_halt_ack = 1; tick(); wfi_halt_ack = 0;
    chk("t5_in_sleep", 32'(sleep_v), 1);
    rst_n = 0; #1;
    chk("t5_sleep_async", 32'(sleep_v), 0);
    chk("t5_halt_async", 32'(halt_v), 0);
    tick(); rst_n = 1; tick();
    chk("t5_idle_halt", 32'(halt_v), 0);

    // T6 debug mode masks interrupt and WFI
    dbg_mode = 1; status_mie_r = 1; irq_i = 4'b0001; irq_en_i = 4'b0001;
    commit(32'h500, 0, 0, 1);
    chk("t6_dbg_no_flush", 32'(if_v.flush_req), 0);
    chk("t6_dbg_no_halt", 32'(halt_v), 0);
    dbg_mode = 0; irq_i = 0; status_mie_r = 0; tick();
    // WFI at top of address space: resume PC wraps to zero
    commit(32'hFFFF_FFFC, 0, 0, 1);
    wfi_halt_ack = 1; tick(); wfi_halt_ack = 0;
    irq_i = 4'b0001; tick(); irq_i = 0;
    chk("t6_wrap_req", 32'(if_v.flush_req), 1);
    chk("t6_wrap_pc", if_v.flush_pc, 32'h0000_0000);
    ack();

    // flush_ack outside FLUSH has no effect
    flush_ack = 1; tick(); tick(); flush_ack = 0;
    chk("stray_ack", 32'(if_v.flush_req), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
